uart_rx_buffer: RTL

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   8N1 UART receiver feeding a 4-entry byte FIFO. The FIFO and the status flags are
//   visible on a simple memory-mapped read bus.
//
//   Parameters
//     BAUD_DIV   clk cycles per serial bit (4..65535)
//     DATA_ADDR  byte address of the RX data register (reading it pops the FIFO)
//     STAT_ADDR  byte address of the RX status register {FERR, OVR, full, nonempty}
//
//   Ports
//     clk     system clock; all state updates on its rising edge
//     reset   synchronous, active-high reset
//     in      asynchronous serial line, idle high, LSB first
//     rd      CPU read strobe
//     addr    CPU byte address
//     rdata   read data; zero when not selected so it can be OR-combined with other slaves
//     irqout  registered "FIFO not empty" interrupt request
module uart_rx_buffer #(
    parameter int unsigned BAUD_DIV  = 5208,
    parameter logic [31:0] DATA_ADDR = 32'h4000_001C,
    parameter logic [31:0] STAT_ADDR = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in,
    input  logic        rd,
    input  logic [31:0] addr,
    output logic [31:0] rdata,
    output logic        irqout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Terminal bit-timer values: middle of the start bit, then one full bit period.
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);

    localparam logic [2:0] FIFO_DEPTH = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        push;
    logic        ferr_set;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = 16'd0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Resample in the middle of the start bit; a high line means a glitch.
                if (timer_q == HALF_LAST) begin
                    timer_d   = 16'd0;
                    bit_cnt_d = 3'd0;
                    state_d   = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                // Timer restarts per bit so every sample lands mid-bit.
                if (timer_q == BIT_LAST) begin
                    timer_d   = 16'd0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = 16'd0;
                    state_d = ST_IDLE;
                    if (rxs) begin
                        push = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
            default: begin
                timer_d = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic data_sel;
    logic stat_sel;

    assign data_sel = rd && (addr == DATA_ADDR);
    assign stat_sel = rd && (addr == STAT_ADDR);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0] mem [4];
    logic [1:0] wptr_q, wptr_d;
    logic [1:0] rptr_q, rptr_d;
    logic [2:0] count_q, count_d;
    logic       pop;
    logic       do_write;
    logic       ovr_set;
    logic       full;
    logic       nonempty;
    logic [7:0] head;

    assign full     = (count_q == FIFO_DEPTH);
    assign nonempty = (count_q != 3'd0);
    assign head     = nonempty ? mem[rptr_q] : 8'h00;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only accepted
    // when a pop frees the head slot in the same cycle.
    assign pop      = data_sel && nonempty;
    assign do_write = push && (!full || pop);
    assign ovr_set  = push && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_write) begin
            wptr_d = wptr_q + 2'd1;
        end
        if (pop) begin
            rptr_d = rptr_q + 2'd1;
        end
        case ({do_write, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem[wptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags and interrupt
    // ------------------------------------------------------------------
    logic ferr_q, ferr_d;
    logic ovr_q, ovr_d;
    logic irq_q;

    // A status read clears the flags, but an event in the same cycle keeps them set.
    always_comb begin
        if (stat_sel) begin
            ferr_d = ferr_set;
            ovr_d  = ovr_set;
        end else begin
            ferr_d = ferr_q | ferr_set;
            ovr_d  = ovr_q | ovr_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            irq_q   <= nonempty;
        end
    end

    assign irqout = irq_q;

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        if (!reset) begin
            if (data_sel) begin
                rdata = {24'h0, head};
            end else if (stat_sel) begin
                rdata = {28'h0, ferr_q, ovr_q, full, nonempty};
            end
        end
    end

endmodule
